mem_arbiter: RTL and testbench

- Two-requester arbiter that shares one main data memory between the instruction cache (I-side, read-only) and the data cache (D-side, read/write).
- Sits between the two cache controllers and the main memory, and uses the same READ/WRITE/BUSYWAIT handshake the CPU already uses toward memory.
- Serialises block transfers, resolves ties round-robin, and flags a memory that never completes.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/arb_rr_pick.sv | 22 ++
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the I/D memory arbiter: FSM states and grant identities.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational two-way round-robin choice: on a tie the side not served last wins.
module arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic valid,
  output logic grant
);

  always_comb begin
    valid = req_i | req_d;
    grant = GNT_I;
    if (req_i && req_d) begin
      grant = ~last_grant;
    end else if (req_d) begin
      grant = GNT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one block memory between the I-cache (read-only) and D-cache (read/write),
// serialising transfers with a READ/WRITE/BUSYWAIT handshake and a sticky timeout flag.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT,
  output logic              ARB_ERROR
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? CNT_MAX : c + 1'b1;
  endfunction

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              first_q, first_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic pick_valid;
  logic pick_grant;
  logic d_req;
  logic d_is_write;
  logic [CNT_W-1:0] cnt_inc;

  assign d_req = D_READ | D_WRITE;

  arb_rr_pick u_pick (
    .req_i      (I_READ),
    .req_d      (d_req),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .grant      (pick_grant)
  );

  // A write wins over a read when the D-side raises both.
  assign d_is_write = D_WRITE;
  assign cnt_inc    = sat_inc(cnt_q);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    first_d      = first_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          first_d = 1'b1;
          cnt_d   = '0;
          state_d = SERVE;
          if (pick_grant == GNT_D) begin
            mem_read_d  = ~d_is_write;
            mem_write_d = d_is_write;
            mem_addr_d  = D_ADDRESS;
            mem_wdata_d = D_WRITEDATA;
          end else begin
            mem_read_d  = 1'b1;
            mem_write_d = 1'b0;
            mem_addr_d  = I_ADDRESS;
          end
        end
      end

      SERVE: begin
        // Memory asserts busywait combinationally, so the first cycle tells us nothing.
        if (first_q) begin
          first_d = 1'b0;
        end else if (!MEM_BUSYWAIT) begin
          if (mem_read_q) begin
            if (grant_q == GNT_D) d_rdata_d = MEM_READDATA;
            else                  i_rdata_d = MEM_READDATA;
          end
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          last_grant_d = grant_q;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) err_d = 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= IDLE;
      grant_q      <= GNT_I;
      last_grant_q <= GNT_I;
      first_q      <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      first_q      <= first_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign I_BUSYWAIT    = I_READ & ~(state_q == RESP && grant_q == GNT_I);
  assign D_BUSYWAIT    = d_req  & ~(state_q == RESP && grant_q == GNT_D);
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;
  assign I_READDATA    = i_rdata_q;
  assign D_READDATA    = d_rdata_q;
  assign ARB_ERROR     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-programmable block memory model.
module tb_mem_arbiter;

  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 128;
  localparam int TIMEOUT = 255;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              I_READ;
  logic [ADDR_W-1:0] I_ADDRESS;
  logic [DATA_W-1:0] I_READDATA;
  logic              I_BUSYWAIT;
  logic              D_READ;
  logic              D_WRITE;
  logic [ADDR_W-1:0] D_ADDRESS;
  logic [DATA_W-1:0] D_WRITEDATA;
  logic [DATA_W-1:0] D_READDATA;
  logic              D_BUSYWAIT;
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [ADDR_W-1:0] MEM_ADDRESS;
  logic [DATA_W-1:0] MEM_WRITEDATA;
  logic [DATA_W-1:0] MEM_READDATA;
  logic              MEM_BUSYWAIT;
  logic              ARB_ERROR;

  int checks = 0;
  int errors = 0;

  int                mem_lat = 1;
  int                mc = 0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .I_READ        (I_READ),
    .I_ADDRESS     (I_ADDRESS),
    .I_READDATA    (I_READDATA),
    .I_BUSYWAIT    (I_BUSYWAIT),
    .D_READ        (D_READ),
    .D_WRITE       (D_WRITE),
    .D_ADDRESS     (D_ADDRESS),
    .D_WRITEDATA   (D_WRITEDATA),
    .D_READDATA    (D_READDATA),
    .D_BUSYWAIT    (D_BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT),
    .ARB_ERROR     (ARB_ERROR)
  );

  // Block contents: address 5 holds all-A5, every other address holds {2'b11, addr} per byte.
  function automatic logic [DATA_W-1:0] blk(input logic [ADDR_W-1:0] a);
    logic [7:0] b;
    b = (a == 6'd5) ? 8'hA5 : {2'b11, a};
    return {16{b}};
  endfunction

  // Busywait stays high for the first mem_lat cycles of each strobe.
  assign MEM_READDATA = blk(MEM_ADDRESS);
  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mc < mem_lat);

  always @(posedge CLK) begin
    if (MEM_READ | MEM_WRITE) mc <= mc + 1;
    else                      mc <= 0;
    if (MEM_WRITE && !MEM_BUSYWAIT && mc != 0) begin
      wr_addr <= MEM_ADDRESS;
      wr_data <= MEM_WRITEDATA;
    end
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_resp(input string tag, input bit side_d, input int budget, output int n);
    n = 0;
    while ((side_d ? D_BUSYWAIT : I_BUSYWAIT) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, DATA_W'(side_d ? D_BUSYWAIT : I_BUSYWAIT), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int n;
    int bad;

    RESET = 1'b0; I_READ = 1'b1; I_ADDRESS = '0;
    D_READ = 1'b0; D_WRITE = 1'b0; D_ADDRESS = '0; D_WRITEDATA = '0;
    mem_lat = 20;

    // Reset with a pending I request
    repeat (2) @(negedge CLK);
    chk("rst_mem_read",  DATA_W'(MEM_READ), '0);
    chk("rst_mem_write", DATA_W'(MEM_WRITE), '0);
    chk("rst_mem_addr",  DATA_W'(MEM_ADDRESS), '0);
    chk("rst_mem_wdata", MEM_WRITEDATA, '0);
    chk("rst_i_rdata",   I_READDATA, '0);
    chk("rst_d_rdata",   D_READDATA, '0);
    chk("rst_err",       DATA_W'(ARB_ERROR), '0);
    chk("rst_i_bw",      DATA_W'(I_BUSYWAIT), DATA_W'(1));

    // Single I read, 20 busy cycles
    I_ADDRESS = 6'h05; RESET = 1'b1;
    @(negedge CLK);
    chk("i1_strobe", DATA_W'(MEM_READ), DATA_W'(1));
    n = 0; bad = 0;
    while (I_BUSYWAIT && n < 100) begin
      if (!MEM_READ || MEM_ADDRESS != 6'h05) bad++;
      @(negedge CLK);
      n++;
    end
    chk("i1_serve_len",   DATA_W'(n), DATA_W'(21));
    chk("i1_strobe_hold", DATA_W'(bad), '0);
    chk("i1_rdata",       I_READDATA, {16{8'hA5}});
    chk("i1_resp_strobe", DATA_W'(MEM_READ), '0);
    I_READ = 1'b0;
    @(negedge CLK);
    chk("i1_idle_strobe", DATA_W'(MEM_READ), '0);
    chk("i1_rdata_hold",  I_READDATA, {16{8'hA5}});

    // Tie after reset: D first
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1; mem_lat = 1;
    I_ADDRESS = 6'h01; I_READ = 1'b1;
    D_ADDRESS = 6'h02; D_WRITE = 1'b1; D_WRITEDATA = 128'h1234;
    @(negedge CLK);
    chk("tie_d_write", DATA_W'(MEM_WRITE), DATA_W'(1));
    chk("tie_d_read",  DATA_W'(MEM_READ), '0);
    chk("tie_d_addr",  DATA_W'(MEM_ADDRESS), DATA_W'(6'h02));
    chk("tie_d_wdata", MEM_WRITEDATA, 128'h1234);
    wait_resp("tie_d_resp", 1'b1, 10, n);
    chk("tie_min_lat", DATA_W'(n), DATA_W'(2));
    chk("tie_i_stall", DATA_W'(I_BUSYWAIT), DATA_W'(1));
    D_WRITE = 1'b0;
    @(negedge CLK);
    chk("tie_bubble", DATA_W'(MEM_READ | MEM_WRITE), '0);
    chk("tie_wr_addr", DATA_W'(wr_addr), DATA_W'(6'h02));
    chk("tie_wr_data", wr_data, 128'h1234);
    @(negedge CLK);
    chk("tie_i_read", DATA_W'(MEM_READ), DATA_W'(1));
    chk("tie_i_addr", DATA_W'(MEM_ADDRESS), DATA_W'(6'h01));
    wait_resp("tie_i_resp", 1'b0, 10, n);
    chk("tie_i_rdata", I_READDATA, {16{8'hC1}});
    chk("tie_d_rdata", D_READDATA, '0);
    I_READ = 1'b0;
    @(negedge CLK);

    // D read raised while I is being served
    mem_lat = 3;
    I_ADDRESS = 6'h07; I_READ = 1'b1;
    @(negedge CLK);
    D_ADDRESS = 6'h09; D_READ = 1'b1;
    @(negedge CLK);
    bad = 0; n = 0;
    while (I_BUSYWAIT && n < 20) begin
      if (!D_BUSYWAIT || MEM_ADDRESS != 6'h07) bad++;
      @(negedge CLK);
      n++;
    end
    chk("dw_i_resp",   DATA_W'(I_BUSYWAIT), '0);
    chk("dw_d_held",   DATA_W'(bad), '0);
    chk("dw_d_stall",  DATA_W'(D_BUSYWAIT), DATA_W'(1));
    I_READ = 1'b0;
    @(negedge CLK);
    chk("dw_bubble_stall", DATA_W'(D_BUSYWAIT), DATA_W'(1));
    chk("dw_bubble_idle",  DATA_W'(MEM_READ), '0);
    @(negedge CLK);
    chk("dw_d_read", DATA_W'(MEM_READ), DATA_W'(1));
    chk("dw_d_addr", DATA_W'(MEM_ADDRESS), DATA_W'(6'h09));
    wait_resp("dw_d_resp", 1'b1, 20, n);
    chk("dw_d_rdata", D_READDATA, {16{8'hC9}});
    chk("dw_i_rdata", I_READDATA, {16{8'hC7}});
    D_READ = 1'b0;
    @(negedge CLK);

    // Second tie after a D transfer: I first
    mem_lat = 1;
    I_ADDRESS = 6'h03; I_READ = 1'b1;
    D_ADDRESS = 6'h04; D_WRITE = 1'b1; D_WRITEDATA = 128'hBEEF;
    @(negedge CLK);
    chk("tie2_i_read", DATA_W'(MEM_READ), DATA_W'(1));
    chk("tie2_i_addr", DATA_W'(MEM_ADDRESS), DATA_W'(6'h03));
    wait_resp("tie2_i_resp", 1'b0, 10, n);
    chk("tie2_i_rdata", I_READDATA, {16{8'hC3}});
    I_READ = 1'b0;
    repeat (2) @(negedge CLK);
    chk("tie2_d_write", DATA_W'(MEM_WRITE), DATA_W'(1));
    chk("tie2_d_addr",  DATA_W'(MEM_ADDRESS), DATA_W'(6'h04));
    wait_resp("tie2_d_resp", 1'b1, 10, n);
    chk("tie2_d_rdata_keep", D_READDATA, {16{8'hC9}});
    D_WRITE = 1'b0;
    @(negedge CLK);
    chk("tie2_wr_data", wr_data, 128'hBEEF);

    // Reset during the 5th SERVE cycle
    mem_lat = 50;
    I_ADDRESS = 6'h05; I_READ = 1'b1;
    repeat (5) @(negedge CLK);
    chk("ab_strobe", DATA_W'(MEM_READ), DATA_W'(1));
    RESET = 1'b0;
    @(negedge CLK);
    chk("ab_read_low", DATA_W'(MEM_READ), '0);
    chk("ab_i_rdata",  I_READDATA, '0);
    chk("ab_d_rdata",  D_READDATA, '0);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (!I_BUSYWAIT) bad++;
      @(negedge CLK);
    end
    chk("ab_no_resp", DATA_W'(bad), '0);
    I_READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    chk("ab_idle", DATA_W'(MEM_READ), '0);

    // Memory stuck busy for 300 cycles
    mem_lat = 300;
    I_ADDRESS = 6'h02; I_READ = 1'b1;
    repeat (256) @(negedge CLK);
    chk("to_before", DATA_W'(ARB_ERROR), '0);
    @(negedge CLK);
    chk("to_set", DATA_W'(ARB_ERROR), DATA_W'(1));
    chk("to_still_serving", DATA_W'(MEM_READ), DATA_W'(1));
    wait_resp("to_resp", 1'b0, 100, n);
    chk("to_resp_cycles", DATA_W'(n), DATA_W'(45));
    chk("to_rdata", I_READDATA, {16{8'hC2}});
    I_READ = 1'b0;
    repeat (3) @(negedge CLK);
    chk("to_sticky", DATA_W'(ARB_ERROR), DATA_W'(1));
    RESET = 1'b0;
    @(negedge CLK);
    chk("to_cleared", DATA_W'(ARB_ERROR), '0);
    RESET = 1'b1;
    @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
